ham_tx_scheduler: RTL
=====================

Name: ham_tx_scheduler

Overview:
- Transmit-side sequencer between the Hamming encoder and the FSK modulator.
- Buffers encoded 14-bit Hamming words in a small FIFO, using a valid/ready handshake on the input.
- Frames each word as: preamble of 0-bits, then data MSB first, then a gap of 1-bits. Each bit is paced by the bit-rate tick from the divider chain.
- Drives a single serial bit to the modulator and reports frame and FIFO status.

Parameters:
- WORD_W, 14: Hamming word width in bits.
- FIFO_DEPTH, 2: number of buffered words. Must be a power of 2, ≥2.
- PREAMBLE_LEN, 2: number of 0-bits sent before the data.
- GAP_LEN, 2: number of 1-bits sent after the data.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- bit_tick, input, 1: one-clk pulse per bit period.
- word_in, input, WORD_W: encoded Hamming word.
- word_valid, input, 1: word_in is valid.
- word_ready, output, 1: FIFO can accept a word.
- tx_bit, output, 1: serial bit to the modulator.
- tx_active, output, 1: high while a frame is in progress (PREAMBLE, DATA or GAP).
- frame_start, output, 1: one-clk pulse on the first preamble bit.
- bit_idx, output, 4: index of the current data bit, WORD_W-1 down to 0. Zero outside DATA.
- fifo_cnt, output, log2(FIFO_DEPTH)+1: number of words held in the FIFO.
- overflow_cnt, output, 8: count of dropped words, saturating.

Behaviour:
- Reset values: word_ready=1, tx_bit=1, tx_active=0, frame_start=0, bit_idx=0, fifo_cnt=0, overflow_cnt=0, FSM=IDLE.
- Reset asserted mid-frame: everything clears immediately. The FIFO contents are discarded and the partial frame is abandoned.
- Input handshake:
  - word_ready = (fifo_cnt != FIFO_DEPTH), derived combinationally from the registered count.
  - A push occurs on a clk edge with word_valid && word_ready. fifo_cnt updates on that same edge.
  - word_valid while full: the word is dropped and overflow_cnt increments, saturating at 255. Push and drop never occur together.
- Pop: the FIFO head is loaded into the shift register on the IDLE→PREAMBLE transition.
- Push and pop on the same edge: fifo_cnt is unchanged.
  - Data is only pushed when the FIFO was not full before the edge.
  - A pop frees space only from the next cycle onward.
- FSM registers change only on edges where bit_tick=1; tx_bit is registered.
  - IDLE: tx_bit=1. On bit_tick with fifo_cnt>0: pop, go to PREAMBLE, tx_bit=0, frame_start=1 for that one clk, preamble counter=1.
  - PREAMBLE: tx_bit=0. On bit_tick: if the counter equals PREAMBLE_LEN, go to DATA with tx_bit=shreg[WORD_W-1] and bit_idx=WORD_W-1; otherwise increment the counter.
  - DATA: tx_bit=shreg[bit_idx]. On bit_tick: if bit_idx=0, go to GAP with tx_bit=1 and gap counter=1; otherwise decrement bit_idx.
  - GAP: tx_bit=1. On bit_tick with the counter equal to GAP_LEN:
    - fifo_cnt>0: go directly to PREAMBLE (pop, frame_start). Back-to-back frames do not pass through an IDLE bit.
    - fifo_cnt=0: go to IDLE.
- Frame length: PREAMBLE_LEN + WORD_W + GAP_LEN bit periods, which is 18 with defaults.
- tx_active=1 in PREAMBLE, DATA and GAP.
- bit_tick asserted on consecutive clocks: each tick advances exactly one bit, with no skipping.
- A word pushed while a frame is in flight is sent in the next frame. The in-flight shift register is never modified.
- Latency: a word pushed into an empty FIFO while IDLE starts its frame at the first bit_tick edge after the push edge. A tick on the push edge itself does not start it.
- Counters wrap never; all counts are bounded by the parameters.

Optional Feature:
- Macro TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and GAP. It lasts one bit period with tx_bit = XOR of the 14 data bits (even parity). Frame length becomes 19.
- Undefined: no PARITY state; DATA goes directly to GAP and the frame is 18 bits.

Test Plan:
- Reset then idle: release reset with no words pushed, run 10 bit_ticks → tx_bit=1, tx_active=0, word_ready=1, fifo_cnt=0 throughout.
- Single frame: push 14'h1A5C, then apply bit_ticks → serial sequence 0,0, then 01 1010 0101 1100, then 1,1. frame_start pulses once; bit_idx runs 13→0; back to IDLE after 18 ticks.
- Back-to-back: push 14'h3FFF and 14'h0000 before the first tick → two frames with no idle bit between them. The second frame_start occurs exactly 18 ticks after the first. fifo_cnt goes 2→1→0.
- Overflow: with FIFO_DEPTH=2 and FSM busy, hold word_valid for 5 clks without pops → 2 accepted, word_ready=0 after the second, overflow_cnt=3.
- Reset mid-frame: assert reset during DATA at bit_idx=7 → immediately tx_bit=1, tx_active=0, fifo_cnt=0. After release, no residual frame is sent.
- TX_PARITY_EN defined: push 14'h0001 → a parity bit of 1 follows data bit 0, and the frame is 19 ticks long.

Source files
------------

// File: rtl/ham_tx_scheduler_if.sv
// Word handshake between the Hamming encoder (master) and the TX scheduler (slave).
interface ham_tx_scheduler_if #(
    parameter int unsigned WORD_W = 14
);
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_in, output word_valid, input word_ready);
    modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/ham_tx_scheduler.sv
// Transmit sequencer: buffers Hamming words and serialises them as
// preamble(0s) + data MSB first + gap(1s), one bit per bit_tick.
// Optional macro TX_PARITY_EN inserts an even-parity bit between data and gap.
module ham_tx_scheduler #(
    parameter int unsigned WORD_W       = 14,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned PREAMBLE_LEN = 2,
    parameter int unsigned GAP_LEN      = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        bit_tick,
    ham_tx_scheduler_if.slave           in_if,
    output logic                        tx_bit,
    output logic                        tx_active,
    output logic                        frame_start,
    output logic [3:0]                  bit_idx,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
    output logic [7:0]                  overflow_cnt
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned PH_MAX = (PREAMBLE_LEN > GAP_LEN) ? PREAMBLE_LEN : GAP_LEN;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_GAP
`ifdef TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [3:0]         idx_d;
    logic [3:0]         idx_m1;
    logic               tx_bit_d;
    logic               pop;
    logic               push;
    logic               drop;
    logic [WORD_W-1:0]  shreg;
    logic [WORD_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;

    // Ready is a pure decode of the registered occupancy.
    assign in_if.word_ready = (fifo_cnt != CNT_W'(FIFO_DEPTH));
    assign push             = in_if.word_valid && in_if.word_ready;
    assign drop             = in_if.word_valid && !in_if.word_ready;
    assign idx_m1           = bit_idx - 4'd1;

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_if.word_in;
    end

    // FIFO pointers, occupancy and saturating drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            overflow_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (drop && (overflow_cnt != 8'hFF)) overflow_cnt <= overflow_cnt + 8'd1;
        end
    end

    // Frame FSM state and registered serial outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            bit_idx     <= '0;
            tx_bit      <= 1'b1;
            tx_active   <= 1'b0;
            frame_start <= 1'b0;
            shreg       <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_idx     <= idx_d;
            tx_bit      <= tx_bit_d;
            tx_active   <= (state_d != S_IDLE);
            frame_start <= pop;
            if (pop) shreg <= mem[rd_ptr];
        end
    end

    // Next-state, next-output and pop decode; everything holds unless bit_tick.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        idx_d    = bit_idx;
        tx_bit_d = tx_bit;
        pop      = 1'b0;
        if (bit_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (fifo_cnt != '0) begin
                        pop      = 1'b1;
                        state_d  = S_PREAMBLE;
                        phase_d  = PH_W'(1);
                        tx_bit_d = 1'b0;
                    end
                end
                S_PREAMBLE: begin
                    if (phase_q == PH_W'(PREAMBLE_LEN)) begin
                        state_d  = S_DATA;
                        idx_d    = 4'(WORD_W - 1);
                        tx_bit_d = shreg[WORD_W-1];
                    end else begin
                        phase_d  = phase_q + PH_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_idx == 4'd0) begin
`ifdef TX_PARITY_EN
                        state_d  = S_PARITY;
                        tx_bit_d = ^shreg;
`else
                        state_d  = S_GAP;
                        phase_d  = PH_W'(1);
                        tx_bit_d = 1'b1;
`endif
                    end else begin
                        idx_d    = idx_m1;
                        tx_bit_d = shreg[idx_m1];
                    end
                end
`ifdef TX_PARITY_EN
                S_PARITY: begin
                    state_d  = S_GAP;
                    phase_d  = PH_W'(1);
                    tx_bit_d = 1'b1;
                end
`endif
                S_GAP: begin
                    if (phase_q == PH_W'(GAP_LEN)) begin
                        if (fifo_cnt != '0) begin
                            pop      = 1'b1;
                            state_d  = S_PREAMBLE;
                            phase_d  = PH_W'(1);
                            tx_bit_d = 1'b0;
                        end else begin
                            state_d  = S_IDLE;
                            tx_bit_d = 1'b1;
                        end
                    end else begin
                        phase_d  = phase_q + PH_W'(1);
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    tx_bit_d = 1'b1;
                end
            endcase
        end
    end
endmodule
